sop_sweep_ctrl: RTL and testbench

- Sequencer that exhaustively exercises a combinational sum-of-products evaluator (e.g. the 2-input XOR-form SoP unit) by stepping through every input vector, waiting for settling, and capturing the response.
- Builds the full truth table in hardware, counts true minterms and compares against an expected minterm mask.
- Replaces hand-written per-vector stimulus lists in benches and in on-chip self-check paths.

---
 rtl/sop_sweep_ctrl.sv | 116 +++++++++++
 tb/tb_sop_sweep_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sop_sweep_ctrl.sv
// Exhaustive truth-table sweeper for a combinational sum-of-products evaluator:
// steps every input vector, waits SETTLE cycles, captures the response and checks it against a mask.
module sop_sweep_ctrl #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic [N_IN-1:0]        eval_vec,
    input  logic                   eval_s,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   truth_tbl,
    output logic [N_IN:0]          ones_cnt,
    output logic                   match
);

    localparam int DEPTH = 1 << N_IN;
    localparam int CW    = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [N_IN-1:0]    r_vec;
    logic [DEPTH-1:0]   r_tbl;
    logic [DEPTH-1:0]   r_exp;
    logic [N_IN:0]      r_ones;
    logic               r_match;
    logic [DEPTH-1:0]   w_tbl_nxt;
    logic               w_settled;
    logic               w_last;

    assign w_settled = (r_cnt == CW'(SETTLE - 1));
    assign w_last    = &r_vec;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE:    if (start) w_state_nxt = DRIVE;
            DRIVE: begin
                busy = 1'b1;
                if (w_settled) w_state_nxt = SAMPLE;
            end
            SAMPLE: begin
                busy        = 1'b1;
                w_state_nxt = w_last ? DONE : DRIVE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Table including the bit being captured this cycle, so match can be
    // registered on the same edge as the final sample.
    always_comb begin
        w_tbl_nxt        = r_tbl;
        w_tbl_nxt[r_vec] = eval_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec   <= '0;
            r_tbl   <= '0;
            r_ones  <= '0;
            r_match <= 1'b0;
            r_exp   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_vec   <= '0;
                        r_tbl   <= '0;
                        r_ones  <= '0;
                        r_match <= 1'b0;
                        r_exp   <= expected;
                        r_cnt   <= '0;
                    end
                end
                DRIVE: r_cnt <= r_cnt + CW'(1);
                SAMPLE: begin
                    r_tbl  <= w_tbl_nxt;
                    // X on eval_s is deliberately allowed to poison the count and match.
                    r_ones <= r_ones + {{N_IN{1'b0}}, eval_s};
                    if (w_last) begin
                        r_match <= (w_tbl_nxt == r_exp);
                    end else begin
                        r_vec <= r_vec + N_IN'(1);
                        r_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign eval_vec  = r_vec;
    assign truth_tbl = r_tbl;
    assign ones_cnt  = r_ones;
    assign match     = r_match;

endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// Directed bench for sop_sweep_ctrl: XOR evaluator on a 2-input instance and a
// driven-constant evaluator on a 4-input instance, with a scoreboard of sweep results.
module tb_sop_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, a_start, b_start, b_s;
    logic [3:0]  a_exp;
    logic [15:0] b_exp;

    logic [1:0]  a_vec;
    logic        a_busy, a_done, a_match, a_s;
    logic [3:0]  a_tbl;
    logic [2:0]  a_ones;

    logic [3:0]  b_vec;
    logic        b_busy, b_done, b_match;
    logic [15:0] b_tbl;
    logic [4:0]  b_ones;

    assign a_s = (~a_vec[1] & a_vec[0]) | (a_vec[1] & ~a_vec[0]);

    sop_sweep_ctrl #(.N_IN(2), .SETTLE(1)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .expected(a_exp),
        .eval_vec(a_vec), .eval_s(a_s), .busy(a_busy), .done(a_done),
        .truth_tbl(a_tbl), .ones_cnt(a_ones), .match(a_match)
    );

    sop_sweep_ctrl #(.N_IN(4), .SETTLE(3)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .expected(b_exp),
        .eval_vec(b_vec), .eval_s(b_s), .busy(b_busy), .done(b_done),
        .truth_tbl(b_tbl), .ones_cnt(b_ones), .match(b_match)
    );

    int          sel;
    logic        m_busy, m_done, m_match;
    logic [3:0]  m_vec;
    logic [15:0] m_tbl;
    logic [4:0]  m_ones;

    always_comb begin
        if (sel == 0) begin
            m_busy = a_busy; m_done = a_done; m_match = a_match;
            m_vec = {2'b00, a_vec}; m_tbl = {12'h000, a_tbl}; m_ones = {2'b00, a_ones};
        end else begin
            m_busy = b_busy; m_done = b_done; m_match = b_match;
            m_vec = b_vec; m_tbl = b_tbl; m_ones = b_ones;
        end
    end

    typedef struct {
        logic [15:0] tbl;
        logic [4:0]  ones;
        logic        m;
        int          dcyc;
        int          bcyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_sweep(input int s, input logic [15:0] mask, input bit hold,
                             input int chg_cyc, input logic [15:0] chg_val,
                             input logic [15:0] etbl, input logic [4:0] eones, input logic em);
        exp_t e;
        int   cyc, busy_n, per, last;
        bit   vec_ok;
        sel  = s;
        per  = (s == 0) ? 2 : 4;
        last = (s == 0) ? 3 : 15;
        if (s == 0) a_exp = mask[3:0]; else b_exp = mask;
        sb.push_back('{tbl: etbl, ones: eones, m: em,
                       dcyc: (s == 0) ? 9 : 65, bcyc: (s == 0) ? 8 : 64});
        if (s == 0) a_start = 1'b1; else b_start = 1'b1;
        tick();
        if (!hold) begin a_start = 1'b0; b_start = 1'b0; end
        chk("tbl_cleared_at_start", {16'h0, m_tbl}, 32'h0);
        cyc = 1; busy_n = 0; vec_ok = 1'b1;
        while (m_done !== 1'b1 && cyc < 200) begin
            if (m_busy === 1'b1) busy_n++;
            if (m_vec !== 4'((cyc - 1) / per)) vec_ok = 1'b0;
            if (cyc == chg_cyc) begin
                if (s == 0) a_exp = chg_val[3:0]; else b_exp = chg_val;
            end
            tick();
            cyc++;
        end
        e = sb.pop_front();
        chk("done_seen", {31'h0, m_done}, 32'h1);
        chk("done_cycle", cyc, e.dcyc);
        chk("busy_cycles", busy_n, e.bcyc);
        chk("vec_sequence", {31'h0, vec_ok}, 32'h1);
        chk("busy_low_in_done", {31'h0, m_busy}, 32'h0);
        chk("truth_tbl", {16'h0, m_tbl}, {16'h0, e.tbl});
        chk("ones_cnt", {27'h0, m_ones}, {27'h0, e.ones});
        chk("match", {31'h0, m_match}, {31'h0, e.m});
        tick();
        if (hold) begin a_start = 1'b0; b_start = 1'b0; end
        chk("done_one_cycle", {31'h0, m_done}, 32'h0);
        chk("idle_busy_low", {31'h0, m_busy}, 32'h0);
        chk("vec_holds_last", {28'h0, m_vec}, last);
        chk("match_held", {31'h0, m_match}, {31'h0, e.m});
        if (hold) begin
            repeat (3) tick();
            chk("no_requeue_busy", {30'h0, m_busy, m_done}, 32'h0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int n;
        rst = 1'b1; a_start = 1'b0; b_start = 1'b0; b_s = 1'b1;
        a_exp = 4'h0; b_exp = 16'h0; sel = 0;
        tick(); tick();
        chk("rst_a_outputs", {a_vec, a_busy, a_done, a_tbl, a_ones, a_match}, 32'h0);
        chk("rst_b_outputs", {b_vec, b_busy, b_done, b_tbl, b_ones, b_match}, 32'h0);
        rst = 1'b0;
        tick();

        // XOR evaluator against matching and non-matching masks.
        run_sweep(0, 16'h0006, 1'b0, 0, 16'h0, 16'h0006, 5'd2, 1'b1);
        run_sweep(0, 16'h0009, 1'b0, 0, 16'h0, 16'h0006, 5'd2, 1'b0);

        // Constant-1 evaluator on the wide instance.
        b_s = 1'b1;
        run_sweep(1, 16'hFFFF, 1'b0, 0, 16'h0, 16'hFFFF, 5'd16, 1'b1);

        // Start held high through the whole sweep and its DONE cycle, then a fresh sweep.
        run_sweep(0, 16'h0006, 1'b1, 0, 16'h0, 16'h0006, 5'd2, 1'b1);
        run_sweep(0, 16'h0009, 1'b0, 0, 16'h0, 16'h0006, 5'd2, 1'b0);

        // Reset in the middle of a sweep.
        sel = 0;
        a_exp = 4'h6; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        n = 0;
        while (a_vec !== 2'd2 && n < 20) begin tick(); n++; end
        chk("reached_vec2", {31'h0, (n < 20)}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_outputs", {a_vec, a_busy, a_done, a_tbl, a_ones, a_match}, 32'h0);
        seen = 1'b0;
        repeat (12) begin tick(); if (a_done !== 1'b0 || a_busy !== 1'b0) seen = 1'b1; end
        chk("midrst_stays_idle", {31'h0, seen}, 32'h0);
        run_sweep(0, 16'h0006, 1'b0, 0, 16'h0, 16'h0006, 5'd2, 1'b1);

        // Expected port changed mid-sweep; the latched mask must be used.
        run_sweep(0, 16'h0006, 1'b0, 4, 16'h0000, 16'h0006, 5'd2, 1'b1);

        // Unknown evaluator output propagates into the table, count and match.
        b_s = 1'bx;
        run_sweep(1, 16'hFFFF, 1'b0, 0, 16'h0, 16'hxxxx, 5'bxxxxx, 1'bx);
        b_s = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
